// File: rtl/decode_stage_p_pkg.sv
// Shared types for the decode stage: op classes, opcode values, instruction
// field layouts and the registered control portion of the output slot.
package decode_stage_p_pkg;

    localparam int unsigned OPC_W    = 6;
    localparam int unsigned REGF_W   = 5;
    localparam int unsigned INSTR_W  = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_ALU_R = 3'd1,
        OP_ADDI  = 3'd2,
        OP_BEQ   = 3'd3,
        OP_LW    = 3'd4,
        OP_SW    = 3'd5,
        OP_J     = 3'd6
    } op_class_e;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OPC_J     = 6'h02;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REGF_W-1:0] rs;
        logic [REGF_W-1:0] rt;
        logic [REGF_W-1:0] rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
    } rtype_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REGF_W-1:0] rs;
        logic [REGF_W-1:0] rt;
        logic [15:0]       imm;
    } itype_t;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [25:0]      target;
    } jtype_t;

    // Register addresses are kept at full field width; the top narrows them.
    typedef struct packed {
        op_class_e         op;
        logic              we;
        logic [REGF_W-1:0] rs_a;
        logic [REGF_W-1:0] rt_a;
        logic [REGF_W-1:0] rd_a;
    } decoded_slot_t;

    function automatic op_class_e decode_op(input logic [OPC_W-1:0] opcode);
        case (opcode)
            OPC_RTYPE: return OP_ALU_R;
            OPC_ADDI:  return OP_ADDI;
            OPC_BEQ:   return OP_BEQ;
            OPC_LW:    return OP_LW;
            OPC_SW:    return OP_SW;
            OPC_J:     return OP_J;
            default:   return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_p_reg_file_bypass.sv
// Architectural register file: two combinational read ports with write-through
// from the single write port; register 0 is hardwired to zero.
module reg_file_bypass #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra_addr_i,
    output logic [XLEN-1:0] ra_data_o_c,
    input  logic [AW-1:0]   rb_addr_i,
    output logic [XLEN-1:0] rb_data_o_c,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] mem_q [NUM_REGS];
    logic            wr_ok;

    assign wr_ok = we_i && (waddr_i != '0) && (32'(waddr_i) < NUM_REGS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle writeback is forwarded so a waiting consumer can issue now.
    always_comb begin
        ra_data_o_c = '0;
        if ((ra_addr_i != '0) && (32'(ra_addr_i) < NUM_REGS)) begin
            ra_data_o_c = (wr_ok && (waddr_i == ra_addr_i)) ? wdata_i : mem_q[ra_addr_i];
        end
    end

    always_comb begin
        rb_data_o_c = '0;
        if ((rb_addr_i != '0) && (32'(rb_addr_i) < NUM_REGS)) begin
            rb_data_o_c = (wr_ok && (waddr_i == rb_addr_i)) ? wdata_i : mem_q[rb_addr_i];
        end
    end

endmodule

// File: rtl/decode_stage_p.sv
// Instruction decode stage: decodes, reads operands with bypass, tracks pending
// destinations for RAW stalls and holds one registered output slot.
module decode_stage_p
    import decode_stage_p_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      NUM_REGS = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    localparam int unsigned     AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output op_class_e       out_op,
    output logic [AW-1:0]   out_rs_a,
    output logic [AW-1:0]   out_rt_a,
    output logic [AW-1:0]   out_rd_a,
    output logic [XLEN-1:0] out_rs,
    output logic [XLEN-1:0] out_rt,
    output logic            out_we,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_jmp,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            hazard
);

    logic                valid_q, valid_d;
    decoded_slot_t       slot_q, slot_d;
    logic [XLEN-1:0]     rs_q, rs_d, rt_q, rt_d, imm_q, imm_d;
    logic [XLEN-1:0]     pc_q, pc_d, pc_jmp_q, pc_jmp_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;

    itype_t          ii;
    op_class_e       dec_op;
    logic [AW-1:0]   f_rs, f_rt, f_rd;
    logic [AW-1:0]   dec_rs_a, dec_rt_a, dec_rd_a;
    logic            dec_we;
    logic [XLEN-1:0] rs_val, rt_val;
    logic            wb_hit_rs, wb_hit_rt, in_fire;

    function automatic logic [AW-1:0] map_reg(input logic [REGF_W-1:0] f);
        return (32'(f) < NUM_REGS) ? AW'(f) : '0;
    endfunction

    assign ii = itype_t'(in_instr);

    // rd of an R-type overlays imm[15:11] of the I-type layout.
    always_comb begin
        dec_op   = decode_op(ii.opcode);
        f_rs     = map_reg(ii.rs);
        f_rt     = map_reg(ii.rt);
        f_rd     = map_reg(ii.imm[15:11]);
        dec_rs_a = '0;
        dec_rt_a = '0;
        dec_rd_a = '0;
        case (dec_op)
            OP_ALU_R: begin
                dec_rs_a = f_rs;
                dec_rt_a = f_rt;
                dec_rd_a = f_rd;
            end
            OP_ADDI, OP_LW: begin
                dec_rs_a = f_rs;
                dec_rd_a = f_rt;
            end
            OP_BEQ, OP_SW: begin
                dec_rs_a = f_rs;
                dec_rt_a = f_rt;
            end
            default: ;
        endcase
        dec_we = (dec_rd_a != '0);
    end

    reg_file_bypass #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_rf (
        .clk         (clk),
        .rst_n       (reset),
        .ra_addr_i   (dec_rs_a),
        .ra_data_o_c (rs_val),
        .rb_addr_i   (dec_rt_a),
        .rb_data_o_c (rt_val),
        .we_i        (wb_en),
        .waddr_i     (wb_rd),
        .wdata_i     (wb_data)
    );

    // Unused sources decode to r0, which is never pending.
    assign wb_hit_rs = wb_en && (wb_rd == dec_rs_a);
    assign wb_hit_rt = wb_en && (wb_rd == dec_rt_a);
    assign hazard    = in_valid && ((pend_q[dec_rs_a] && !wb_hit_rs) ||
                                    (pend_q[dec_rt_a] && !wb_hit_rt));
    assign in_ready  = reset && !flush && !hazard && (!valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;

    // Scoreboard: writeback and flush clear, a newly issued writer sets last.
    always_comb begin
        pend_d = pend_q;
        if (wb_en && (32'(wb_rd) < NUM_REGS)) begin
            pend_d[wb_rd] = 1'b0;
        end
        if (flush && valid_q && slot_q.we) begin
            pend_d[AW'(slot_q.rd_a)] = 1'b0;
        end
        if (in_fire && dec_we) begin
            pend_d[dec_rd_a] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        valid_d  = valid_q;
        slot_d   = slot_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        pc_jmp_d = pc_jmp_q;
        if (flush || (!in_fire && valid_q && out_ready)) begin
            valid_d  = 1'b0;
            pc_d     = RESET_PC;
            pc_jmp_d = RESET_PC;
        end else if (in_fire) begin
            valid_d     = 1'b1;
            slot_d.op   = dec_op;
            slot_d.we   = dec_we;
            slot_d.rs_a = REGF_W'(dec_rs_a);
            slot_d.rt_a = REGF_W'(dec_rt_a);
            slot_d.rd_a = REGF_W'(dec_rd_a);
            rs_d        = rs_val;
            rt_d        = rt_val;
            imm_d       = {{(XLEN-16){ii.imm[15]}}, ii.imm};
            pc_d        = in_pc;
            pc_jmp_d    = {in_pc[XLEN-1:28], in_instr[25:0], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            slot_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            pc_q     <= RESET_PC;
            pc_jmp_q <= RESET_PC;
            pend_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            slot_q   <= slot_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            pc_jmp_q <= pc_jmp_d;
            pend_q   <= pend_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_op     = slot_q.op;
    assign out_we     = slot_q.we;
    assign out_rs_a   = AW'(slot_q.rs_a);
    assign out_rt_a   = AW'(slot_q.rt_a);
    assign out_rd_a   = AW'(slot_q.rd_a);
    assign out_rs     = rs_q;
    assign out_rt     = rt_q;
    assign out_imm    = imm_q;
    assign out_pc     = pc_q;
    assign out_pc_jmp = pc_jmp_q;

endmodule
